// File: rtl/mux4_rr_arbiter_if.sv
// Bus between the requesters and the round-robin arbiter that drives the
// 4:1 mux select lines.
interface mux4_rr_arbiter_if;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic       S0;
    logic       S1;
    logic       VALID;

    modport master (output REQ, input GNT, input S0, input S1, input VALID);
    modport slave  (input REQ, output GNT, output S0, output S1, output VALID);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 single-bit mux between channels A..D.
// Registers a one-hot grant plus the matching S0/S1 select lines, and
// limits how long one owner may keep the mux while others are waiting.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 8
) (
    input logic              CLK,
    input logic              RST_N,
    mux4_rr_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [1:0]       owner;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [3:0]       gnt_q;
    logic             s0_q;
    logic             s1_q;
    logic             valid_q;

    logic [3:0]       req;
    logic [2:0]       idle_pick;
    logic [2:0]       hand_pick;
    logic             owner_req;
    logic             others_req;
    logic             take;
    logic [1:0]       take_idx;
    logic             end_grant;
    logic             go_idle;
    logic             bump;

    // First requester in rotation order starting at 'start': {found, index}.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Scan from the farthest offset down so the nearest requester wins.
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Clean the request lines so an unknown bit reads as "not requesting".
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (bus.REQ[i]) req[i] = 1'b1;
            else            req[i] = 1'b0;
        end
    end

    assign idle_pick  = pick(req, ptr);
    assign hand_pick  = pick(req, owner + 2'd1);
    assign owner_req  = req[owner];
    assign others_req = |(req & ~(4'b0001 << owner));

    // Arbitration decision for the coming edge.
    always_comb begin
        take      = 1'b0;
        take_idx  = 2'd0;
        end_grant = 1'b0;
        go_idle   = 1'b0;
        bump      = 1'b0;
        case (state)
            IDLE: begin
                if (idle_pick[2]) begin
                    take     = 1'b1;
                    take_idx = idle_pick[1:0];
                end
            end
            BUSY: begin
                if (!owner_req || (others_req && hold_cnt == HOLD_LIM)) begin
                    end_grant = 1'b1;
                    if (others_req) begin
                        take     = 1'b1;
                        take_idx = hand_pick[1:0];
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (hold_cnt != HOLD_LIM) begin
                    bump = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FSM with registered grant, selects and valid; all update on one edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            owner    <= 2'd0;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            gnt_q    <= 4'b0000;
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (end_grant) ptr <= owner + 2'd1;
            if (take) begin
                state    <= BUSY;
                owner    <= take_idx;
                hold_cnt <= CNT_W'(1);
                gnt_q    <= 4'b0001 << take_idx;
                s0_q     <= take_idx[1];
                s1_q     <= take_idx[0];
                valid_q  <= 1'b1;
            end else if (go_idle) begin
                state   <= IDLE;
                gnt_q   <= 4'b0000;
                valid_q <= 1'b0;
            end else if (bump) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.GNT   = gnt_q;
    assign bus.S0    = s0_q;
    assign bus.S1    = s1_q;
    assign bus.VALID = valid_q;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares the 4:1 single-bit mux between four requesters (channels A, B, C, D). It registers a one-hot grant and drives the mux select lines S0/S1 so that the granted channel's data reaches Z. A per-grant hold limit stops one requester from monopolising the mux while others wait. It sits directly in front of the mux's S0/S1 inputs.

Parameters:
HOLD_MAX, 4, maximum consecutive cycles one owner keeps the grant while another request is pending; legal range 1..255
CNT_W, 8, width of the hold counter; must hold HOLD_MAX

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
REQ  input  4  request lines; bit0=A, bit1=B, bit2=C, bit3=D; level-sensitive
GNT  output  4  registered one-hot grant, same bit order as REQ; all-zero when idle
S0  output  1  mux select 0, registered
S1  output  1  mux select 1, registered
VALID  output  1  high when GNT is non-zero, i.e. Z carries a granted channel

Behaviour:
- Single clock domain, CLK. Reset is asynchronous and active-low on RST_N. Reset takes effect immediately, independent of CLK.
- Reset values: GNT=0000, S0=0, S1=0, VALID=0, state=IDLE, hold count=0. Round-robin pointer=0, so A has highest priority after reset.
- Select encoding matches the mux decode:
  - A: S0=0, S1=0
  - B: S0=0, S1=1
  - C: S0=1, S1=0
  - D: S0=1, S1=1
- S0, S1, GNT and VALID change only on the same CLK edge, so they are always mutually consistent. In IDLE, S0/S1 hold their last value.
- Priority order is round-robin starting at the pointer: ptr, ptr+1, ptr+2, ptr+3, mod 4. When a grant ends for owner i, the pointer becomes (i+1) mod 4.
- State IDLE:
  - REQ=0000: stay in IDLE.
  - REQ non-zero: at the next edge, grant the first requester in priority order and go to BUSY. Hold count is set to 1.
  - Latency from REQ sampled high to GNT high is 1 cycle.
- State BUSY, with owner o:
  - Release: REQ[o]=0 at an edge. If any other REQ bit is high, hand off directly to the next requester after o in round-robin order at that same edge, with no idle bubble. Hold count is set to 1. Otherwise go to IDLE with GNT=0000 and VALID=0.
  - Hold expiry: REQ[o]=1, hold count = HOLD_MAX, and at least one other REQ bit high. Force a handoff to the next requester after o at that edge. The old owner re-enters the rotation normally.
  - Keep: REQ[o]=1 and no other request pending. Keep the grant; the hold count saturates at HOLD_MAX and does not wrap.
  - Otherwise: keep the grant and increment the hold count.
- The owner therefore holds the grant for at most HOLD_MAX cycles while others wait. With HOLD_MAX=1, the grant rotates every cycle under full load.
- Requests arriving or dropping mid-grant have no effect until the next arbitration decision.
- A single requester never starves: it is granted within 3*HOLD_MAX+1 cycles of asserting REQ, provided it holds REQ.
- Asserting RST_N low at any point, including mid-grant, returns all outputs to their reset values at once. The first arbitration after reset release uses pointer=0.
- GNT is never multi-hot. An X on REQ must not propagate to GNT in simulation; the bench checks this.

Test Plan:
- Reset/single request: RST_N low, then high; REQ=0100 -> next edge GNT=0100, S0=1, S1=0, VALID=1. Drop REQ -> next edge GNT=0000, VALID=0, S0/S1 hold 1/0.
- Simultaneous requests after reset: REQ=1111 with HOLD_MAX=4 -> grant order A,B,C,D,A, each held exactly 4 cycles. S1S0 sequence is 00,10,01,11 (S1 listed first). No idle cycles between grants.
- Early release handoff: A granted, REQ=0011; A drops REQ after 2 cycles -> B granted at that edge (S0=0, S1=1), hold count restarts at 1.
- Lone owner holds: REQ=1000 held for 20 cycles -> GNT=1000 for all 20 cycles, with no forced release. Then raise REQ[0] -> A granted within 1 cycle, because the hold count is already saturated.
- HOLD_MAX=1 corner: REQ=0101 -> GNT alternates A,C every cycle; S0 toggles each cycle and S1 stays 0.
- Reset mid-operation: C granted under full load, RST_N pulsed low for half a cycle -> GNT=0000, S0=S1=0 and VALID=0 immediately, with no CLK edge needed. After release with REQ=1111 -> A granted first.
